// File: rtl/multi_comparer_if.sv
// Byte-stream and verdict signals between the sentence front end and multi_comparer.
// The master drives the stream; the slave reports the verdict.
interface multi_comparer_if #(
   parameter int N = 3
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic          restart;
   logic          load;
   logic [7:0]    data;
   logic [N-1:0]  enable;
   logic          resolve;
   logic          reject;
   logic [IW-1:0] match_id;
   logic          busy;

   modport master (output restart, load, data, enable,
                   input  resolve, reject, match_id, busy);
   modport slave  (input  restart, load, data, enable,
                   output resolve, reject, match_id, busy);
endinterface

// File: rtl/multi_comparer.sv
// Streaming N-channel matcher: compares incoming bytes against N reference strings of
// length L with optional wildcard and case folding, and reports the lowest matching channel.
module multi_comparer #(
   parameter int             N         = 3,
   parameter int             L         = 5,
   parameter logic [N*L*8-1:0] REFS    = "GPZDAGPGGAGPRMC",
   parameter logic [7:0]     WILDCARD  = "?",
   parameter bit             CASE_FOLD = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   multi_comparer_if.slave   bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = (L > 1) ? $clog2(L) : 1;

   typedef enum logic [1:0] {IDLE, COMPARE, RESOLVED, REJECTED} state_t;

   state_t        state_reg, state_next;
   logic [PW-1:0] pos_reg, pos_next;
   logic [N-1:0]  alive_reg, alive_next;
   logic [IW-1:0] id_reg, id_next;
   logic [N-1:0]  match_vec;
   logic [N-1:0]  hit;
   logic [IW-1:0] lowest;

   function automatic logic [7:0] fold(input logic [7:0] b);
      if (CASE_FOLD && b >= 8'h61 && b <= 8'h7A)
         return b - 8'h20;
      return b;
   endfunction

   // pos_reg is 0 whenever the FSM is IDLE, so it always selects the byte under test.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         logic [7:0] ref_byte;
         assign ref_byte      = REFS[((N - gi) * L - int'(pos_reg)) * 8 - 1 -: 8];
         assign match_vec[gi] = (ref_byte == WILDCARD) || (fold(ref_byte) == fold(bus.data));
      end
   endgenerate

   assign hit = ((state_reg == IDLE) ? bus.enable : alive_reg) & match_vec;

   always_comb begin
      lowest = '0;
      for (int i = N - 1; i >= 0; i--)
         if (hit[i]) lowest = IW'(i);
   end

   always_comb begin
      state_next = state_reg;
      pos_next   = pos_reg;
      alive_next = alive_reg;
      id_next    = id_reg;
      if (bus.restart) begin
         state_next = IDLE;
         pos_next   = '0;
         alive_next = '0;
         id_next    = '0;
      end else if (bus.load && (state_reg == IDLE || state_reg == COMPARE)) begin
         alive_next = hit;
         if (hit == '0) begin
            state_next = REJECTED;
         end else if (pos_reg == PW'(L - 1)) begin
            state_next = RESOLVED;
            id_next    = lowest;
         end else begin
            state_next = COMPARE;
            pos_next   = pos_reg + PW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         pos_reg   <= '0;
         alive_reg <= '0;
         id_reg    <= '0;
      end else begin
         state_reg <= state_next;
         pos_reg   <= pos_next;
         alive_reg <= alive_next;
         id_reg    <= id_next;
      end
   end

   assign bus.resolve  = (state_reg == RESOLVED);
   assign bus.reject   = (state_reg == REJECTED);
   assign bus.busy     = (state_reg == COMPARE);
   assign bus.match_id = id_reg;
endmodule

// File: tb/tb_multi_comparer.sv
// Directed bench: three matcher configurations share one byte stream; each step checks
// {resolve, reject, busy, match_id} of the instance under test against hand-derived values.
module tb_multi_comparer;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       restart_r = 1'b0;
   logic       load_r = 1'b0;
   logic [7:0] data_r = 8'h00;
   logic [2:0] en_a = 3'b000;
   logic [1:0] en_b = 2'b00;
   logic [2:0] en_c = 3'b000;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clock = ~clock;

   multi_comparer_if #(.N(3)) if_a ();
   multi_comparer_if #(.N(2)) if_b ();
   multi_comparer_if #(.N(3)) if_c ();

   assign if_a.restart = restart_r;
   assign if_a.load    = load_r;
   assign if_a.data    = data_r;
   assign if_a.enable  = en_a;
   assign if_b.restart = restart_r;
   assign if_b.load    = load_r;
   assign if_b.data    = data_r;
   assign if_b.enable  = en_b;
   assign if_c.restart = restart_r;
   assign if_c.load    = load_r;
   assign if_c.data    = data_r;
   assign if_c.enable  = en_c;

   multi_comparer u_a (.clock(clock), .reset_n(reset_n), .bus(if_a.slave));
   multi_comparer #(.N(2), .L(5), .REFS("GP???GPGGA")) u_b (.clock(clock), .reset_n(reset_n), .bus(if_b.slave));
   multi_comparer #(.CASE_FOLD(1'b1)) u_c (.clock(clock), .reset_n(reset_n), .bus(if_c.slave));

   // {resolve, reject, busy, match_id[1:0]}
   logic [4:0] obs_a, obs_b, obs_c;
   assign obs_a = {if_a.resolve, if_a.reject, if_a.busy, if_a.match_id};
   assign obs_b = {if_b.resolve, if_b.reject, if_b.busy, 1'b0, if_b.match_id};
   assign obs_c = {if_c.resolve, if_c.reject, if_c.busy, if_c.match_id};

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
      $display("check %-14s rrbid=%b expected=%b", tag, obs, exp);
   endtask

   task automatic step(input logic ld, input logic [7:0] d);
      load_r = ld;
      data_r = d;
      @(posedge clock);
      #1;
      load_r = 1'b0;
   endtask

   task automatic do_restart();
      restart_r = 1'b1;
      @(posedge clock);
      #1;
      restart_r = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("reset_a", obs_a, 5'b000_00);
      reset_n = 1'b1;
      step(1'b0, 8'h00);

      // 1: GPZDA on the default config
      en_a = 3'b111;
      step(1'b1, "G");  chk("t1_G_busy", obs_a, 5'b001_00);
      step(1'b1, "P");
      step(1'b1, "Z");
      step(1'b1, "D");  chk("t1_D_busy", obs_a, 5'b001_00);
      step(1'b1, "A");  chk("t1_resolve", obs_a, 5'b100_00);

      // 2: early reject, then ignore further bytes
      do_restart();     chk("t2_restart", obs_a, 5'b000_00);
      step(1'b1, "G");
      step(1'b1, "P");  chk("t2_P_busy", obs_a, 5'b001_00);
      step(1'b1, "X");  chk("t2_reject", obs_a, 5'b010_00);
      step(1'b1, "G");
      step(1'b1, "P");
      step(1'b1, "R");
      step(1'b1, "M");
      step(1'b1, "C");  chk("t2_held", obs_a, 5'b010_00);

      // 3: wildcard channel and lowest-index priority
      do_restart();
      en_b = 2'b11;
      step(1'b1, "G"); step(1'b1, "P"); step(1'b1, "G"); step(1'b1, "G"); step(1'b1, "A");
      chk("t3_lowest", obs_b, 5'b100_00);
      do_restart();
      en_b = 2'b10;
      step(1'b1, "G");
      en_b = 2'b01;     // late enable change must be ignored
      step(1'b1, "P"); step(1'b1, "G"); step(1'b1, "G"); step(1'b1, "A");
      chk("t3_en_10", obs_b, 5'b100_01);

      // 4: case folding
      do_restart();
      en_a = 3'b111;
      en_c = 3'b111;
      step(1'b1, "g");  chk("t4_nofold_rej", obs_a, 5'b010_00);
      chk("t4_fold_busy", obs_c, 5'b001_00);
      step(1'b1, "p"); step(1'b1, "r"); step(1'b1, "m"); step(1'b1, "c");
      chk("t4_fold_res", obs_c, 5'b100_10);

      // 5: gaps in load, then restart beating a simultaneous byte
      do_restart();
      step(1'b1, "G"); step(1'b1, "P");
      step(1'b0, "Z"); step(1'b0, "Z"); step(1'b0, "Z");
      chk("t5_gap_busy", obs_a, 5'b001_00);
      step(1'b1, "R"); step(1'b1, "M"); step(1'b1, "C");
      chk("t5_resolve", obs_a, 5'b100_10);
      restart_r = 1'b1;
      step(1'b1, "G");
      restart_r = 1'b0;
      chk("t5_rst_load", obs_a, 5'b000_00);
      step(1'b1, "P");  chk("t5_discarded", obs_a, 5'b010_00);

      // enable all-zero at the first byte
      do_restart();
      en_a = 3'b000;
      step(1'b1, "G");  chk("en_zero_rej", obs_a, 5'b010_00);
      en_a = 3'b111;

      // 6: asynchronous reset mid-comparison
      do_restart();
      step(1'b1, "G"); step(1'b1, "P"); step(1'b1, "Z");
      chk("t6_pre", obs_a, 5'b001_00);
      #2 reset_n = 1'b0;
      #1 chk("t6_async", obs_a, 5'b000_00);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;
      step(1'b1, "G"); step(1'b1, "P"); step(1'b1, "Z"); step(1'b1, "D"); step(1'b1, "A");
      chk("t6_resolve", obs_a, 5'b100_00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/multi_comparer.md
Name: multi_comparer

Overview:
- Streaming byte-pattern matcher for the GPZDA sentence front end; N-channel, wildcard-capable successor of the single-string comparer.
- Consumes one ASCII byte per cycle when load is high.
- Compares the stream against N reference strings of length L in parallel; reports which one matched or that none can match.
- Sits after the UART byte stream and '$' detector; selects the NMEA sentence ID before field parsing.

Parameters:
- N, 3, number of reference strings (channels), 1..16.
- L, 5, characters per reference string, 1..32.
- REFS, "GPZDAGPGGAGPRMC", N*L*8-bit packed references. Channel 0 occupies the most significant L bytes; the first character of each string is its most significant byte.
- WILDCARD, "?", reference byte that matches any data byte.
- CASE_FOLD, 0, 1 = ASCII letters compared case-insensitively on both sides.

Ports:
- clock, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- restart, input, 1, synchronous: abandon current comparison and re-arm.
- load, input, 1, data valid; one byte consumed per cycle while high.
- data, input, 8, input byte.
- enable, input, N, per-channel enable, sampled when the first byte is consumed.
- resolve, output, 1, a channel matched all L bytes; held until restart.
- reject, output, 1, no channel can match; held until restart.
- match_id, output, clog2(N) (min 1), index of the matching channel; valid while resolve=1.
- busy, output, 1, comparison in progress (at least one byte consumed, no verdict yet).

Behaviour:
- Reset: resolve=0, reject=0, match_id=0, busy=0; state IDLE; pos=0; alive=0.
- States: IDLE, COMPARE, RESOLVED, REJECTED.
- pos: 0..L-1 byte counter. alive: N-bit live-channel vector.
- Byte k of channel i is REFS[((N-i)*L-k)*8-1 -: 8].
- A byte matches when ref byte == WILDCARD, or equal after optional case fold. Case fold maps 'a'..'z' to 'A'..'Z' only.
- IDLE, load=1:
  - alive <= enable & match-vector(byte 0).
  - If L==1 and any alive: RESOLVED. If alive is empty: REJECTED. Otherwise COMPARE with pos=1.
- COMPARE, load=1:
  - alive <= alive & match-vector(pos).
  - If the result is 0: REJECTED.
  - Else if pos==L-1: RESOLVED, match_id = lowest set index of the new alive.
  - Else pos+1.
- COMPARE, load=0: hold all state; gaps are allowed.
- RESOLVED / REJECTED: load ignored; outputs held until restart.
- Latency: resolve/reject rise on the clock edge that samples the deciding byte, so they are visible the following cycle. reject fires early, at the first byte where all channels have died, not only after L bytes.
- busy = (state==COMPARE).
- restart=1 (any state): next state IDLE, pos=0, alive=0, outputs cleared. restart beats a simultaneous load, and that byte is discarded.
- enable == 0 at the first byte: REJECTED after that byte.
- Multiple channels alive at the end (duplicates or wildcards): the lowest index wins.
- Changes to enable after the first byte have no effect until the next restart.
- reset_n low mid-comparison: immediate return to reset values, independent of clock.
- resolve and reject are never high together.

Test Plan:
1. Default params, enable=3'b111, stream "G","P","Z","D","A" with load=1 → resolve=1 one cycle after "A", match_id=0; busy=1 from after "G" until the verdict; reject stays 0.
2. Stream "G","P","X" → reject=1 one cycle after "X"; busy falls; following bytes "GPRMC" are ignored until restart.
3. REFS="GP???GPGGA", N=2, stream "GPGGA" → resolve, match_id=0 (lowest wins). Repeat with enable=2'b10 → match_id=1.
4. CASE_FOLD=1, stream "gprmc" → resolve, match_id=2. With CASE_FOLD=0, the same stream → reject after "g".
5. Stream "GP", drop load for 3 cycles, then "RMC" → resolve, match_id=2. Assert restart together with load and data="G" → outputs 0, state IDLE, byte discarded.
6. Pulse reset_n low between clock edges during "GPZ" → all outputs 0 immediately. After release, "GPZDA" resolves normally with match_id=0.
